spi_omega_tx: RTL and testbench
===============================

Name: spi_omega_tx

Overview:
SPI master (mode 0, MSB first) that serialises a 40-bit omega word onto sckPort/mosiPort/sselPort. It is the transmitting end of the link consumed by getOmega. It is used in the test/stimulus FPGA and in loopback benches to drive the sigma-delta frequency word into the main design. A single-word valid/ready load interface feeds it, and it reports frame completion with a one-cycle pulse.

Parameters:
WIDTH, 40, bits per frame (omega word width)
CLK_DIV, 4, CLK67MHZ cycles per SCK half-period; legal range >= 2
GAP_CYCLES, 8, minimum cycles with sselPort high between frames; legal range >= 1

Ports:
CLK67MHZ  in  1  system clock; all logic on posedge
resetPort  in  1  asynchronous, active-low reset
load_data  in  WIDTH  word to transmit
load_valid  in  1  load request
load_ready  out  1  high only in IDLE; transfer occurs when load_valid && load_ready
abort  in  1  synchronous frame abort
sckPort  out  1  SPI clock; idles low (CPOL=0)
mosiPort  out  1  serial data; changes only while sckPort is low
sselPort  out  1  active-low slave select
busy  out  1  high from the accept cycle until the end of GAP
done  out  1  one-cycle pulse when sselPort deasserts after a complete frame

Behaviour:
- Reset (resetPort=0, acts immediately): sckPort=0, sselPort=1, mosiPort=0, load_ready=0, busy=0, done=0, shift register=0, counters=0, state=IDLE. First cycle after release: load_ready=1.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: load_ready=1. On accept, capture load_data. Next cycle: sselPort=0, mosiPort=load_data[WIDTH-1], busy=1, go to SETUP.
- SETUP: hold for CLK_DIV cycles with sckPort=0, then go to SHIFT.
- SHIFT: for each bit, sckPort=1 for CLK_DIV cycles, then sckPort=0 for CLK_DIV cycles. The receiver samples on the rising edge. mosiPort advances to the next bit in the same cycle sckPort falls. After WIDTH rising edges and the final low half-period, go to HOLD. mosiPort then reads 0.
- HOLD: 0 cycles beyond the final low half-period. sselPort rises in the cycle after that half-period ends; done=1 in that same cycle. Go to GAP.
- Frame timing: sselPort low for exactly CLK_DIV*(2*WIDTH+1) cycles (324 cycles at the defaults).
- GAP: sselPort=1, sckPort=0, for GAP_CYCLES cycles. Then IDLE with load_ready=1. If load_valid is held high, the next frame is accepted on the first IDLE cycle, so back-to-back frames have exactly GAP_CYCLES+1 cycles of sselPort high.
- load_data and load_valid are ignored while load_ready=0. No queuing.
- abort (any state other than IDLE/GAP): next cycle sckPort=0, sselPort=1, mosiPort=0, done stays 0, go to GAP. A full gap is still enforced. abort in IDLE/GAP has no effect. abort together with an accept in IDLE: the accept wins and abort is ignored.
- Counters: half-period counter is clog2(CLK_DIV) bits, wrapping at CLK_DIV-1. Bit counter is clog2(WIDTH+1) bits. No other arithmetic.

Optional Feature:
SPI_OMEGA_TX_PARITY_EN
- Defined: after bit 0, one extra bit is appended carrying even parity (XOR of all WIDTH data bits). The frame then has WIDTH+1 rising edges, and sselPort is low for CLK_DIV*(2*WIDTH+3) cycles. All other timing is unchanged.
- Undefined: exactly WIDTH bits per frame; no parity logic is synthesised.

Decomposition:
- Shared package spi_omega_pkg: state enum encoding (IDLE, SETUP, SHIFT, HOLD, GAP), default constants OMEGA_WIDTH=40, SPI_CLK_DIV=4, SPI_GAP_CYCLES=8.
- One natural sub-module, spi_half_period_tick. It holds the CLK_DIV counter with enable/clear and outputs a one-cycle tick at wrap. The FSM consumes this tick.

Test Plan:
- Defaults, load 40'h12_3456_789A: bench samples mosiPort on each sckPort rise. Expect 40 edges, captured word 40'h12_3456_789A, sselPort low 324 cycles, one done pulse coincident with sselPort rise.
- load_valid held high with two words (40'hFF_FFFF_FFFF then 40'h0): sselPort high exactly 9 cycles between frames. load_ready low throughout both frames. Second frame captures 40'h0.
- Loopback into getOmega, word 40'h00_0100_0000: omegaOut equals 40'h00_0100_0000 after sselPort rises.
- abort asserted after the 20th rising edge: next cycle sselPort=1 and sckPort=0, no done pulse, load_ready returns after 8 gap cycles.
- resetPort driven low mid-SHIFT (bit 10), asynchronously: outputs reach idle values without waiting for a clock edge. After release, load_ready=1 and a new frame of 40'hA5_A5A5_A5A5 transmits correctly.
- With SPI_OMEGA_TX_PARITY_EN defined, load 40'h1: 41 rising edges, last bit=1, sselPort low 332 cycles.

Source files
------------

// File: rtl/spi_omega_pkg.sv
// Shared types and default constants for the omega-word SPI transmitter.
package spi_omega_pkg;

  localparam int unsigned OMEGA_WIDTH    = 40;
  localparam int unsigned SPI_CLK_DIV    = 4;
  localparam int unsigned SPI_GAP_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/spi_half_period_tick.sv
// Free-running CLK_DIV divider with enable/clear; tick_c marks the last cycle of each half-period.
module spi_half_period_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c
);

  localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_c = en_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_omega_tx.sv
// Mode-0 MSB-first SPI master for the 40-bit omega word.
// Define SPI_OMEGA_TX_PARITY_EN to append an even-parity bit after bit 0.
module spi_omega_tx
  import spi_omega_pkg::*;
#(
  parameter int unsigned WIDTH      = OMEGA_WIDTH,
  parameter int unsigned CLK_DIV    = SPI_CLK_DIV,
  parameter int unsigned GAP_CYCLES = SPI_GAP_CYCLES
) (
  input  logic             CLK67MHZ,
  input  logic             resetPort,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             abort,
  output logic             sckPort,
  output logic             mosiPort,
  output logic             sselPort,
  output logic             busy,
  output logic             done
);

`ifdef SPI_OMEGA_TX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             sck_q, sck_d;
  logic             ssel_q, ssel_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             accept_c, abort_hit_c, cnt_en_c, tick_c, fill_bit_c;

  spi_half_period_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (CLK67MHZ),
    .rst_ni (resetPort),
    .en_i   (cnt_en_c),
    .clr_i  (abort_hit_c),
    .tick_c (tick_c)
  );

  // Bit shifted into the vacated LSB; after the last data bit it surfaces as the parity bit.
`ifdef SPI_OMEGA_TX_PARITY_EN
  logic parity_q;
  always_ff @(posedge CLK67MHZ or negedge resetPort) begin
    if (!resetPort)    parity_q <= 1'b0;
    else if (accept_c) parity_q <= ^load_data;
  end
  assign fill_bit_c = parity_q;
`else
  assign fill_bit_c = 1'b0;
`endif

  always_ff @(posedge CLK67MHZ or negedge resetPort) begin
    if (!resetPort) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sck_q   <= 1'b0;
      ssel_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sck_q   <= sck_d;
      ssel_q  <= ssel_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    sck_d       = sck_q;
    ssel_d      = ssel_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;
    accept_c    = 1'b0;
    abort_hit_c = 1'b0;
    cnt_en_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_valid && ready_q) begin
          accept_c = 1'b1;
          shift_d  = load_data;
          bit_d    = '0;
          sck_d    = 1'b0;
          ssel_d   = 1'b0;
          mosi_d   = load_data[WIDTH-1];
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP, ST_SHIFT, ST_HOLD: begin
        cnt_en_c = 1'b1;
        if (abort) begin
          abort_hit_c = 1'b1;
          sck_d       = 1'b0;
          ssel_d      = 1'b1;
          mosi_d      = 1'b0;
          gap_d       = '0;
          state_d     = ST_GAP;
        end else if (tick_c) begin
          if (state_q == ST_SETUP) begin
            sck_d   = 1'b1;
            state_d = ST_SHIFT;
          end else if (state_q == ST_HOLD) begin
            // HOLD is the final low half-period; deselect on its last edge.
            ssel_d  = 1'b1;
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = ST_GAP;
          end else if (sck_q) begin
            sck_d   = 1'b0;
            bit_d   = bit_q + BW'(1);
            shift_d = {shift_q[WIDTH-2:0], fill_bit_c};
            if (bit_q == BW'(NBITS - 1)) begin
              mosi_d  = 1'b0;
              state_d = ST_HOLD;
            end else begin
              mosi_d = shift_q[WIDTH-2];
            end
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                               gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  assign sckPort    = sck_q;
  assign sselPort   = ssel_q;
  assign mosiPort   = mosi_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_spi_omega_tx.sv
// Directed self-checking bench for spi_omega_tx with a receiving SPI slave model.
module tb_spi_omega_tx;

  logic        clk;
  logic        rst_n;
  logic [39:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic        abort;
  logic        sck, mosi, ssel, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Receiver / monitor state (written only by the negedge monitor, cleared by clear_mon)
  logic [63:0] cap;
  logic [39:0] omega_rx;
  logic        last_bit;
  int          edges, low_cnt, done_cnt, done_bad, ready_bad, high_run, last_high_run;
  logic        sck_prev, ssel_prev;

  spi_omega_tx dut (
    .CLK67MHZ   (clk),
    .resetPort  (rst_n),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .abort      (abort),
    .sckPort    (sck),
    .mosiPort   (mosi),
    .sselPort   (ssel),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sck && !sck_prev) begin
        cap      = {cap[62:0], mosi};
        last_bit = mosi;
        edges++;
      end
      if (ssel && !ssel_prev) omega_rx = cap[39:0];
      if (!ssel) begin
        low_cnt++;
        if (load_ready) ready_bad++;
        if (high_run != 0) last_high_run = high_run;
        high_run = 0;
      end else begin
        high_run++;
      end
      if (done) begin
        done_cnt++;
        if (!(ssel && !ssel_prev)) done_bad++;
      end
    end
    sck_prev  = sck;
    ssel_prev = ssel;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    cap = '0; edges = 0; low_cnt = 0; done_cnt = 0; done_bad = 0; ready_bad = 0;
    high_run = 0; last_high_run = 0;
  endtask

  task automatic send(input logic [39:0] d);
    load_data  = d;
    load_valid = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  // Returns on the posedge following the done pulse.
  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_edges(input int k, input string tag);
    int n = 0;
    while (edges < k && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (edges < k) check({tag, "_timeout"}, 64'(edges), 64'(k));
  endtask

  // Counts cycles until load_ready; n starts at the given offset from the reference edge.
  task automatic cycles_to_ready(input int start, output int n);
    n = start;
    while (!load_ready && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; load_data = '0; load_valid = 1'b0; abort = 1'b0;
    sck_prev = 1'b0; ssel_prev = 1'b1; omega_rx = '0; last_bit = 1'b0;
    clear_mon();
    #23;
    check("rst_sck",   64'(sck),        64'd0);
    check("rst_ssel",  64'(ssel),       64'd1);
    check("rst_mosi",  64'(mosi),       64'd0);
    check("rst_ready", 64'(load_ready), 64'd0);
    check("rst_busy",  64'(busy),       64'd0);
    check("rst_done",  64'(done),       64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("rel_ready", 64'(load_ready), 64'd1);

    // Single frame
    clear_mon();
    send(40'h12_3456_789A);
    check("f1_ssel_low", 64'(ssel),       64'd0);
    check("f1_busy",     64'(busy),       64'd1);
    check("f1_ready",    64'(load_ready), 64'd0);
    check("f1_mosi_msb", 64'(mosi),       64'd0);
    wait_done("f1");
    #1 check("f1_mosi_end", 64'(mosi), 64'd0);
    cycles_to_ready(1, n);
    check("f1_gap",      64'(n),          64'd8);
    check("f1_edges",    64'(edges),      64'd40);
    check("f1_word",     cap & 64'hFF_FFFF_FFFF, 64'h12_3456_789A);
    check("f1_low",      64'(low_cnt),    64'd324);
    check("f1_done_cnt", 64'(done_cnt),   64'd1);
    check("f1_done_pos", 64'(done_bad),   64'd0);
    check("f1_busy_end", 64'(busy),       64'd0);

    // Back-to-back frames with load_valid held high
    @(posedge clk); #1;
    clear_mon();
    load_data  = 40'hFF_FFFF_FFFF;
    load_valid = 1'b1;
    @(posedge clk);
    #1 load_data = 40'h0;
    wait_done("b1");
    check("b1_word", cap & 64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF);
    n = 0;
    while (ssel && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    load_valid = 1'b0;
    cap = '0; edges = 0; done_cnt = 0;
    wait_done("b2");
    check("b2_word",  cap & 64'hFF_FFFF_FFFF, 64'h0);
    check("b2_edges", 64'(edges),         64'd40);
    check("b_gap",    64'(last_high_run), 64'd9);
    check("b_ready",  64'(ready_bad),     64'd0);
    cycles_to_ready(1, n);

    // Loopback receiver
    clear_mon();
    send(40'h00_0100_0000);
    wait_done("lb");
    check("lb_omega", 64'(omega_rx), 64'h00_0100_0000);
    cycles_to_ready(1, n);

    // Abort mid-frame
    clear_mon();
    send(40'hC3_C3C3_C3C3);
    wait_edges(20, "ab");
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("ab_ssel", 64'(ssel), 64'd1);
    check("ab_sck",  64'(sck),  64'd0);
    check("ab_mosi", 64'(mosi), 64'd0);
    cycles_to_ready(0, n);
    check("ab_gap",  64'(n),        64'd8);
    check("ab_done", 64'(done_cnt), 64'd0);

    // Asynchronous reset mid-shift
    clear_mon();
    send(40'h5A_5A5A_5A5A);
    wait_edges(10, "rs");
    #2 rst_n = 1'b0;
    #1;
    check("rs_sck",   64'(sck),        64'd0);
    check("rs_ssel",  64'(ssel),       64'd1);
    check("rs_mosi",  64'(mosi),       64'd0);
    check("rs_ready", 64'(load_ready), 64'd0);
    check("rs_busy",  64'(busy),       64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("rs_ready_rel", 64'(load_ready), 64'd1);
    clear_mon();
    send(40'hA5_A5A5_A5A5);
    wait_done("rs2");
    check("rs2_word",  cap & 64'hFF_FFFF_FFFF, 64'hA5_A5A5_A5A5);
    check("rs2_edges", 64'(edges),   64'd40);
    check("rs2_low",   64'(low_cnt), 64'd324);
    cycles_to_ready(1, n);

`ifdef SPI_OMEGA_TX_PARITY_EN
    clear_mon();
    send(40'h1);
    wait_done("par");
    check("par_edges", 64'(edges),    64'd41);
    check("par_last",  64'(last_bit), 64'd1);
    check("par_word",  cap & 64'h1FF_FFFF_FFFF, 64'h3);
    check("par_low",   64'(low_cnt),  64'd332);
    cycles_to_ready(1, n);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
